// File: rtl/usb_gpx_conditioner.sv
// Conditions the raw MAX3421E GPX pin: synchroniser, stable-count glitch filter,
// edge capture with maskable interrupt, and a small Avalon-MM register slave.
module usb_gpx_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int EDGE_TYPE     = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        gpx_pin,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        gpx_filtered
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_out;
  logic [CW-1:0]          cnt;
  logic                   filtered;
  logic                   prev;
  logic                   mask;
  logic                   capture;
  logic                   rise;
  logic                   fall;
  logic                   ev;
  logic                   wr_en;
  logic                   rd_bit;
  logic                   unused_wd;

  assign unused_wd = ^writedata[31:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], gpx_pin};
  end

  assign s_out = sync[SYNC_STAGES-1];

  // A disagreeing level must persist FILTER_CYCLES cycles; any return resets progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      filtered <= 1'b0;
    end else if (s_out == filtered) begin
      cnt <= '0;
    end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
      cnt      <= '0;
      filtered <= s_out;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= 1'b0;
    else          prev <= filtered;
  end

  assign rise = filtered & ~prev;
  assign fall = ~filtered & prev;

  always_comb begin
    ev = 1'b0;
    case (EDGE_TYPE)
      0:       ev = rise;
      1:       ev = fall;
      default: ev = rise | fall;
    endcase
  end

  assign wr_en = chipselect & ~write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       mask <= 1'b0;
    else if (wr_en && address == 2'd2)  mask <= writedata[0];
  end

  // A new edge outranks a simultaneous software clear so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                      capture <= 1'b0;
    else if (ev)                                       capture <= 1'b1;
    else if (wr_en && address == 2'd3 && writedata[0]) capture <= 1'b0;
  end

  always_comb begin
    rd_bit = 1'b0;
    case (address)
      2'd0: rd_bit = filtered;
      2'd1: rd_bit = s_out;
      2'd2: rd_bit = mask;
      2'd3: rd_bit = capture;
      default: rd_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= {31'b0, rd_bit};
  end

  assign irq          = capture & mask;
  assign gpx_filtered = filtered;

endmodule

// File: tb/tb_usb_gpx_conditioner.sv
// Bench for usb_gpx_conditioner: three instances (rising, falling, any edge)
// share pin and bus; register reads are scored against an expected-value queue.
module tb_usb_gpx_conditioner;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        gpx_pin = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;
  logic        filt0, filt1, filt2;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  usb_gpx_conditioner #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .gpx_pin(gpx_pin), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(rd0), .irq(irq0), .gpx_filtered(filt0));
  usb_gpx_conditioner #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .EDGE_TYPE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .gpx_pin(gpx_pin), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(rd1), .irq(irq1), .gpx_filtered(filt1));
  usb_gpx_conditioner #(.SYNC_STAGES(2), .FILTER_CYCLES(4), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .gpx_pin(gpx_pin), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(rd2), .irq(irq2), .gpx_filtered(filt2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a read; expected data for each instance is queued, then popped when readdata lands.
  task automatic rd(input logic [1:0] a, input logic [31:0] e0, input logic [31:0] e1,
                    input logic [31:0] e2, input string tag);
    address = a;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    tick();
    chk({tag, "/rise"}, rd0, exp_q.pop_front());
    chk({tag, "/fall"}, rd1, exp_q.pop_front());
    chk({tag, "/any"},  rd2, exp_q.pop_front());
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk_irq(input logic e0, input logic e1, input logic e2, input string tag);
    chk({tag, "/irq_rise"}, {31'b0, irq0}, {31'b0, e0});
    chk({tag, "/irq_fall"}, {31'b0, irq1}, {31'b0, e1});
    chk({tag, "/irq_any"},  {31'b0, irq2}, {31'b0, e2});
  endtask

  logic [7:0] raw_pat;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    tick();
    chk("rst_filt", {31'b0, filt0}, 32'd0);
    chk("rst_rd", rd0, 32'd0);
    chk_irq(1'b0, 1'b0, 1'b0, "rst");
    reset_n = 1'b1;
    tick();

    // Clean rising step: exactly 6 cycles of latency.
    gpx_pin = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("rise_lat_low", {31'b0, filt0}, 32'd0);
    end
    tick();
    chk("rise_lat_high", {31'b0, filt0}, 32'd1);
    chk("rise_lat_high_any", {31'b0, filt2}, 32'd1);
    rd(2'd3, 32'd0, 32'd0, 32'd0, "cap_pre");
    rd(2'd3, 32'd1, 32'd0, 32'd1, "cap_rise");
    rd(2'd0, 32'd1, 32'd1, 32'd1, "data_hi");
    rd(2'd1, 32'd1, 32'd1, 32'd1, "raw_hi");
    wr(2'd3, 32'd1);
    rd(2'd3, 32'd0, 32'd0, 32'd0, "cap_clr");

    // Falling step.
    gpx_pin = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("fall_filt", {31'b0, filt1}, 32'd0);
    rd(2'd3, 32'd0, 32'd1, 32'd1, "cap_fall");
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, 32'd0, 32'd0, 32'd0, "cap_clr2");

    // Three-cycle glitch never accepted; RAW shows a 3-cycle pulse.
    raw_pat = 8'b0001_1100;
    gpx_pin = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      rd(2'd1, {31'b0, raw_pat[i-1]}, {31'b0, raw_pat[i-1]}, {31'b0, raw_pat[i-1]}, "raw_glitch");
      chk("glitch_filt", {31'b0, filt2}, 32'd0);
      if (i == 3) gpx_pin = 1'b0;
    end
    rd(2'd3, 32'd0, 32'd0, 32'd0, "glitch_cap");
    rd(2'd0, 32'd0, 32'd0, 32'd0, "glitch_data");

    // Interrupt masking and RW1C behaviour.
    wr(2'd2, 32'd1);
    rd(2'd2, 32'd1, 32'd1, 32'd1, "mask_rd");
    chk_irq(1'b0, 1'b0, 1'b0, "irq_idle");
    gpx_pin = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk_irq(1'b1, 1'b0, 1'b1, "irq_rise");
    wr(2'd3, 32'd0);
    chk_irq(1'b1, 1'b0, 1'b1, "irq_w0");
    rd(2'd3, 32'd1, 32'd0, 32'd1, "cap_w0");
    wr(2'd3, 32'd1);
    chk_irq(1'b0, 1'b0, 1'b0, "irq_w1");

    // Clear coinciding with the edge event: set wins.
    gpx_pin = 1'b0;
    for (int i = 1; i <= 5; i++) tick();
    chk("fall_lat_hi", {31'b0, filt1}, 32'd1);
    tick();
    chk("fall_lat_lo", {31'b0, filt1}, 32'd0);
    chk_irq(1'b0, 1'b0, 1'b0, "irq_pre_ev");
    wr(2'd3, 32'd1);
    chk_irq(1'b0, 1'b1, 1'b1, "irq_setwins");
    tick();
    chk_irq(1'b0, 1'b1, 1'b1, "irq_hold");

    // Asynchronous reset in the middle of filtering (counter at 2).
    gpx_pin = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_rd", rd1, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_filt", {31'b0, filt0}, 32'd0);
    chk("arst_rd", rd1, 32'd0);
    chk_irq(1'b0, 1'b0, 1'b0, "arst");
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("post_rst_low", {31'b0, filt0}, 32'd0);
    end
    tick();
    chk("post_rst_high", {31'b0, filt0}, 32'd1);
    tick();
    rd(2'd3, 32'd1, 32'd0, 32'd1, "post_rst_cap");
    chk_irq(1'b0, 1'b0, 1'b0, "post_rst_masked");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
